// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode and state definitions for the ALU issue stage
package alu_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND     = 3'b000;
    localparam logic [OP_W-1:0] OP_OR      = 3'b001;
    localparam logic [OP_W-1:0] OP_XOR     = 3'b010;
    localparam logic [OP_W-1:0] OP_XNOR    = 3'b011;
    localparam logic [OP_W-1:0] OP_ADD     = 3'b100;
    localparam logic [OP_W-1:0] OP_SUB     = 3'b101;
    localparam logic [OP_W-1:0] OP_NOT     = 3'b110;
    localparam logic [OP_W-1:0] OP_ILLEGAL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    function automatic logic op_has_carry(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_settle_counter.sv
// rtl/alu_settle_counter.sv - loadable down-counter timing the operand settle window
module alu_settle_counter #(
    parameter int CW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic          zero
);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - CW'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - issue/capture front end holding operands on the function-unit bus
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [OP_W-1:0]  in_op,
    output logic [WIDTH-1:0] fu_a,
    output logic [WIDTH-1:0] fu_b,
    output logic [OP_W-1:0]  fu_op,
    input  logic [WIDTH-1:0] fu_result,
    input  logic             fu_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_ones,
    output logic             out_carry,
    output logic             out_err,
    output logic [CNT_W-1:0] txn_count
);

    localparam int              SC_W    = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SC_W-1:0] SC_LOAD = SC_W'(SETTLE_CYCLES - 1);

    state_t state, state_nxt;
    logic   in_fire, out_fire, cnt_zero, capture;

    // in_ready must never look at in_valid, so it is a pure state/out_ready decode
    assign out_valid = (state == ST_DONE);
    assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign capture   = (state == ST_EXEC) && cnt_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_fire) state_nxt = ST_EXEC;
            ST_EXEC: if (cnt_zero) state_nxt = ST_DONE;
            ST_DONE: if (out_fire) state_nxt = in_valid ? ST_EXEC : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    alu_settle_counter #(
        .CW(SC_W)
    ) u_settle (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (in_fire),
        .load_val (SC_LOAD),
        .dec      (state == ST_EXEC),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fu_a  <= '0;
            fu_b  <= '0;
            fu_op <= '0;
        end else if (in_fire) begin
            fu_a  <= in_a;
            fu_b  <= in_b;
            fu_op <= in_op;
        end
    end

    // Illegal opcodes report err only; whatever the function units return is discarded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_result <= '0;
            out_zero   <= 1'b0;
            out_ones   <= 1'b0;
            out_carry  <= 1'b0;
            out_err    <= 1'b0;
        end else if (capture) begin
            if (fu_op == OP_ILLEGAL) begin
                out_result <= '0;
                out_zero   <= 1'b0;
                out_ones   <= 1'b0;
                out_carry  <= 1'b0;
                out_err    <= 1'b1;
            end else begin
                out_result <= fu_result;
                out_zero   <= (fu_result == '0);
                out_ones   <= &fu_result;
                out_carry  <= op_has_carry(fu_op) && fu_carry;
                out_err    <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_count <= '0;
        end else if (out_fire) begin
            txn_count <= txn_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - directed self-checking bench for alu_issue_stage
module tb_alu_issue_stage;
    import alu_pkg::*;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic [3:0] res;
        logic       zero;
        logic       ones;
        logic       carry;
        logic       err;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int exp_txn  = 0;

    // SETTLE_CYCLES=1 instance
    logic       rst1_n, in_valid1, in_ready1, out_valid1, out_ready1;
    logic [3:0] in_a1, in_b1, fu_a1, fu_b1, fu_result1, out_result1;
    logic [2:0] in_op1, fu_op1;
    logic       fu_carry1, out_zero1, out_ones1, out_carry1, out_err1;
    logic [7:0] txn1;

    // SETTLE_CYCLES=3 instance
    logic       rst3_n, in_valid3, in_ready3, out_valid3, out_ready3;
    logic [3:0] in_a3, in_b3, fu_a3, fu_b3, fu_result3, out_result3;
    logic [2:0] in_op3, fu_op3;
    logic       fu_carry3, out_zero3, out_ones3, out_carry3, out_err3;
    logic [7:0] txn3;

    // Function-unit model; carry is deliberately 1 on logic ops and illegal returns junk
    function automatic logic [4:0] fu_model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        case (op)
            OP_AND:  return {1'b1, a & b};
            OP_OR:   return {1'b1, a | b};
            OP_XOR:  return {1'b1, a ^ b};
            OP_XNOR: return {1'b1, ~(a ^ b)};
            OP_ADD:  return {1'b0, a} + {1'b0, b};
            OP_SUB:  return {1'b0, a} - {1'b0, b};
            OP_NOT:  return {1'b1, ~a};
            default: return 5'b11010;
        endcase
    endfunction

    assign {fu_carry1, fu_result1} = fu_model(fu_op1, fu_a1, fu_b1);
    assign {fu_carry3, fu_result3} = fu_model(fu_op3, fu_a3, fu_b3);

    alu_issue_stage #(.WIDTH(4), .SETTLE_CYCLES(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst1_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_a(in_a1), .in_b(in_b1), .in_op(in_op1),
        .fu_a(fu_a1), .fu_b(fu_b1), .fu_op(fu_op1),
        .fu_result(fu_result1), .fu_carry(fu_carry1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_result(out_result1),
        .out_zero(out_zero1), .out_ones(out_ones1), .out_carry(out_carry1), .out_err(out_err1),
        .txn_count(txn1)
    );

    alu_issue_stage #(.WIDTH(4), .SETTLE_CYCLES(3), .CNT_W(8)) dut3 (
        .clk(clk), .rst_n(rst3_n), .in_valid(in_valid3), .in_ready(in_ready3),
        .in_a(in_a3), .in_b(in_b3), .in_op(in_op3),
        .fu_a(fu_a3), .fu_b(fu_b3), .fu_op(fu_op3),
        .fu_result(fu_result3), .fu_carry(fu_carry3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_result(out_result3),
        .out_zero(out_zero3), .out_ones(out_ones3), .out_carry(out_carry3), .out_err(out_err3),
        .txn_count(txn3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        in_a1 = v.a; in_b1 = v.b; in_op1 = v.op; in_valid1 = 1'b1; out_ready1 = 1'b0;
        chk($sformatf("v%0d in_ready", idx), in_ready1, 1);
        tick();
        in_valid1 = 1'b0;
        lat = 0;
        while (!out_valid1 && lat < 20) begin
            tick();
            lat++;
        end
        chk($sformatf("v%0d latency", idx), lat, 1);
        chk($sformatf("v%0d result", idx), out_result1, v.res);
        chk($sformatf("v%0d flags", idx), {out_zero1, out_ones1, out_carry1, out_err1},
            {v.zero, v.ones, v.carry, v.err});
        out_ready1 = 1'b1;
        tick();
        out_ready1 = 1'b0;
        exp_txn = (exp_txn + 1) % 256;
        chk($sformatf("v%0d txn", idx), txn1, exp_txn);
        chk($sformatf("v%0d valid_drop", idx), out_valid1, 0);
    endtask

    initial begin
        vec_t vecs[12];
        int   lat, hs, cyc, first_hs, last_hs;

        vecs[0]  = '{4'b1010, 4'b1100, OP_XNOR,    4'b1001, 0, 0, 0, 0};
        vecs[1]  = '{4'b1111, 4'b1111, OP_XNOR,    4'b1111, 0, 1, 0, 0};
        vecs[2]  = '{4'b0000, 4'b0000, OP_XNOR,    4'b1111, 0, 1, 0, 0};
        vecs[3]  = '{4'b1111, 4'b0001, OP_ADD,     4'b0000, 1, 0, 1, 0};
        vecs[4]  = '{4'b1010, 4'b0101, OP_ILLEGAL, 4'b0000, 0, 0, 0, 1};
        vecs[5]  = '{4'b0011, 4'b0101, OP_SUB,     4'b1110, 0, 0, 1, 0};
        vecs[6]  = '{4'b0101, 4'b0011, OP_SUB,     4'b0010, 0, 0, 0, 0};
        vecs[7]  = '{4'b1100, 4'b1010, OP_AND,     4'b1000, 0, 0, 0, 0};
        vecs[8]  = '{4'b1100, 4'b1010, OP_OR,      4'b1110, 0, 0, 0, 0};
        vecs[9]  = '{4'b1100, 4'b0011, OP_XOR,     4'b1111, 0, 1, 0, 0};
        vecs[10] = '{4'b0000, 4'b1011, OP_NOT,     4'b1111, 0, 1, 0, 0};
        vecs[11] = '{4'b0011, 4'b0100, OP_ADD,     4'b0111, 0, 0, 0, 0};

        rst1_n = 1'b0; in_valid1 = 1'b0; out_ready1 = 1'b0; in_a1 = '0; in_b1 = '0; in_op1 = '0;
        rst3_n = 1'b0; in_valid3 = 1'b0; out_ready3 = 1'b0; in_a3 = '0; in_b3 = '0; in_op3 = '0;
        tick();
        tick();
        rst1_n = 1'b1;
        rst3_n = 1'b1;
        tick();

        chk("rst in_ready", in_ready1, 1);
        chk("rst out_valid", out_valid1, 0);
        chk("rst fu_bus", {fu_a1, fu_b1, fu_op1}, 0);
        chk("rst outputs", {out_result1, out_zero1, out_ones1, out_carry1, out_err1}, 0);
        chk("rst txn", txn1, 0);

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // Backpressure: result held for 5 cycles, then release with a new request on the same edge
        in_a1 = 4'b1010; in_b1 = 4'b0101; in_op1 = OP_AND; in_valid1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        lat = 0;
        while (!out_valid1 && lat < 20) begin tick(); lat++; end
        chk("bp latency", lat, 1);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("bp%0d valid", c), out_valid1, 1);
            chk($sformatf("bp%0d result", c), {out_result1, out_zero1}, 5'b00001);
            chk($sformatf("bp%0d in_ready", c), in_ready1, 0);
            chk($sformatf("bp%0d fu_a", c), fu_a1, 4'b1010);
        end
        in_a1 = 4'b0011; in_b1 = 4'b0100; in_op1 = OP_ADD; in_valid1 = 1'b1; out_ready1 = 1'b1;
        #1;
        chk("bp release in_ready", in_ready1, 1);
        tick();
        in_valid1 = 1'b0; out_ready1 = 1'b0;
        exp_txn = (exp_txn + 1) % 256;
        chk("bp no bubble fu_a", {fu_a1, fu_b1, fu_op1}, {4'b0011, 4'b0100, OP_ADD});
        chk("bp txn", txn1, exp_txn);
        chk("bp exec valid", out_valid1, 0);
        tick();
        chk("bp second valid", out_valid1, 1);
        chk("bp second result", out_result1, 4'b0111);

        // SETTLE_CYCLES=3: reset mid-EXEC discards the transaction
        in_a3 = 4'b1010; in_b3 = 4'b0011; in_op3 = OP_XOR; in_valid3 = 1'b1;
        tick();
        in_valid3 = 1'b0;
        chk("s3 fu_a latched", fu_a3, 4'b1010);
        tick();
        rst3_n = 1'b0;
        #1;
        chk("s3 rst valid", out_valid3, 0);
        chk("s3 rst fu_bus", {fu_a3, fu_b3, fu_op3}, 0);
        tick();
        rst3_n = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        chk("s3 post rst valid", out_valid3, 0);
        chk("s3 post rst txn", txn3, 0);
        chk("s3 post rst in_ready", in_ready3, 1);

        // SETTLE_CYCLES=3 latency with operands held stable through EXEC
        in_a3 = 4'b1100; in_b3 = 4'b1010; in_op3 = OP_OR; in_valid3 = 1'b1;
        tick();
        in_valid3 = 1'b0; in_a3 = 4'b0000; in_b3 = 4'b0000;
        lat = 0;
        while (!out_valid3 && lat < 20) begin
            chk($sformatf("s3 hold%0d", lat), {fu_a3, fu_b3}, {4'b1100, 4'b1010});
            tick();
            lat++;
        end
        chk("s3 latency", lat, 3);
        chk("s3 result", out_result3, 4'b1110);
        out_ready3 = 1'b1;
        tick();
        out_ready3 = 1'b0;
        chk("s3 txn", txn3, 1);

        // 256 back-to-back handshakes from reset wrap txn_count to zero
        rst1_n = 1'b0;
        tick();
        rst1_n = 1'b1;
        in_a1 = 4'b0001; in_b1 = 4'b0001; in_op1 = OP_ADD; in_valid1 = 1'b1; out_ready1 = 1'b1;
        hs = 0; cyc = 0; first_hs = 0; last_hs = 0;
        while (hs < 256 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (out_valid1) begin
                if (hs == 0) first_hs = cyc;
                last_hs = cyc;
                hs++;
                if (hs == 256) chk("wrap pre txn", txn1, 255);
            end
        end
        chk("wrap handshakes", hs, 256);
        chk("wrap throughput", last_hs - first_hs, 510);
        tick();
        in_valid1 = 1'b0;
        chk("wrap txn", txn1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Sequential front end of the integer ALU. Accepts an operand/opcode transaction over a valid/ready handshake and holds the operands stable on the function-unit bus (AND/OR/XOR/XNOR/ADD/SUB gates) for a programmable settle window. It then captures the selected function-unit result with derived flags into an output register and presents it downstream over a second valid/ready handshake.

## Interface
- WIDTH, 4, operand/result width in bits
- SETTLE_CYCLES, 1, cycles operands are held on the function-unit bus before capture (≥1)
- CNT_W, 8, width of the transaction counter
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream transaction valid
- in_ready  output  1  stage can accept a transaction
- in_a, in_b  input  WIDTH  operands
- in_op  input  3  opcode
- fu_a, fu_b  output  WIDTH  registered operands driven to the function units
- fu_op  output  3  registered opcode driven to the result mux
- fu_result  input  WIDTH  combinational result returned by the function units
- fu_carry  input  1  carry/borrow from ADD/SUB unit
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_result  output  WIDTH  registered result
- out_zero, out_ones, out_carry, out_err  output  1  result == 0; result all ones; carry/borrow (ADD/SUB only, else 0); illegal opcode
- txn_count  output  CNT_W  number of results accepted downstream

One clock; reset is asynchronous and active-low.

## Operation
- Opcodes: 000 AND, 001 OR, 010 XOR, 011 XNOR, 100 ADD, 101 SUB (a−b), 110 NOT a, 111 illegal.
- States: IDLE, EXEC, DONE.
- IDLE: in_ready=1. in_valid&in_ready → latch in_a/in_b/in_op into fu_a/fu_b/fu_op, load settle counter with SETTLE_CYCLES−1, go EXEC.
- EXEC: in_ready=0. Counter decrements each cycle. At counter==0, capture fu_result, fu_carry, flags into output registers, go DONE.
  - Opcode 111: out_result=0, out_err=1, out_zero=0, out_ones=0, out_carry=0; fu_result is ignored.
- DONE: out_valid=1 and outputs held stable until out_valid&out_ready. in_ready=out_ready.
  - Handshake with in_valid=0 → IDLE.
  - Handshake with in_valid=1 → new transaction latched same edge, go EXEC.
- txn_count increments on each out_valid&out_ready and wraps modulo 2^CNT_W.
- fu_a/fu_b/fu_op change only on an input handshake. They are stable throughout EXEC and DONE.
- out_valid must not drop before the handshake. in_ready depends combinationally only on state and out_ready, never on in_valid.

## Timing
- Reset: state IDLE, in_ready=1 while reset is deasserted, out_valid=0, fu_a/fu_b/fu_op=0, out_result=0, all flags=0, txn_count=0.
- Input accepted at edge T → EXEC for cycles T+1…T+SETTLE_CYCLES → out_valid=1 from cycle T+SETTLE_CYCLES+1. Latency = SETTLE_CYCLES+1.
- Peak throughput with out_ready held high: one result per SETTLE_CYCLES+1 cycles.
- Reset asserted mid-EXEC or mid-DONE: in-flight transaction is discarded and all registers return to reset values immediately. txn_count does not count it.
- out_ready high while not in DONE: no effect.
- txn_count wrap: 0xFF + 1 → 0x00 with CNT_W=8.

## Structure
- Shared package alu_pkg: opcode localparams (OP_AND…OP_ILLEGAL), op width constant, state enum encoding. The function units and the result mux import the same opcode definitions.
- Sub-module alu_settle_counter: loadable down-counter with a zero flag, sized clog2(SETTLE_CYCLES+1).
- Function units stay external. This block contains no arithmetic except flag derivation.

## Test plan
- Reset then XNOR: a=1010, b=1100, op=011, fu model returns 1001 → out_result=1001, out_zero=0, out_ones=0, out_valid at T+2 (SETTLE_CYCLES=1).
- Equality via XNOR: a=1111, b=1111 → out_result=1111, out_ones=1; a=0000, b=0000 → out_ones=1.
- ADD overflow: a=1111, b=0001, op=100 → out_result=0000, out_zero=1, out_carry=1. Op 111 → out_err=1, out_result=0000.
- Backpressure: out_ready=0 for 5 cycles → out_valid and outputs stable, in_ready=0. Release with in_valid=1 → new transaction accepted on the same edge, no bubble.
- SETTLE_CYCLES=3: fu_a/fu_b constant through EXEC, out_valid at T+4. Reset pulse during EXEC → out_valid=0, txn_count unchanged.
- 256 back-to-back transactions → txn_count wraps to 0x00.
